serdesphy_link_seq: RTL and testbench

- Bring-up and recovery sequencer for the SerDes PHY analog resources.
- After power is good and the PHY is enabled, it:
  - pulses and releases the PLL reset, waits for a filtered PLL lock;
  - pulses and releases the CDR reset, waits for a filtered CDR lock;
  - enables the TX/RX datapaths and asserts phy_ready.
- Monitors lock loss, retries on timeout, latches a fault after too many failures.
- Sits in the PCS between the POR/CSR blocks and the PLL/CDR/TX/RX blocks.

---
 rtl/serdesphy_pkg.sv | 29 ++
 rtl/serdesphy_lock_filter.sv | 43 ++++
 rtl/serdesphy_link_seq.sv | 173 +++++++++++++++++
 tb/tb_serdesphy_link_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// Shared state encoding and default timing for the SerDes PHY bring-up sequencer.
// Defaults assume the 24 MHz reference clock.
package serdesphy_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE     = 3'd0,
      SEQ_PLL_RST  = 3'd1,
      SEQ_PLL_WAIT = 3'd2,
      SEQ_CDR_RST  = 3'd3,
      SEQ_CDR_WAIT = 3'd4,
      SEQ_READY    = 3'd5,
      SEQ_FAULT    = 3'd6
   } seq_state_e;

   localparam int DEF_RST_PULSE   = 48;
   localparam int DEF_PLL_TIMEOUT = 24000;
   localparam int DEF_CDR_TIMEOUT = 12000;
   localparam int DEF_LOCK_FILTER = 16;
   localparam int DEF_MAX_RETRIES = 3;

   localparam logic [3:0] RETRY_SAT = 4'd15;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/serdesphy_lock_filter.sv
// Raw-lock qualifier: stable on the LOCK_FILTER-th consecutive high sample, lost after two lows.
// Combinational outputs off registered history; no backpressure.
module serdesphy_lock_filter
   import serdesphy_pkg::*;
#(
   parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_lock_raw,
   output logic o_lock_stable,
   output logic o_lock_lost
);

   localparam int            CW  = $clog2(LOCK_FILTER + 1);
   localparam logic [CW-1:0] SAT = CW'(LOCK_FILTER);

   logic [CW-1:0] r_run;
   logic          r_prev_raw;
   logic [CW-1:0] w_run_nxt;

   always_comb begin
      w_run_nxt = '0;
      if (i_lock_raw) begin
         w_run_nxt = (r_run == SAT) ? SAT : r_run + CW'(1);
      end
   end

   // r_prev_raw resets high so a single low right after reset is not a loss.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_run      <= '0;
         r_prev_raw <= 1'b1;
      end else begin
         r_run      <= w_run_nxt;
         r_prev_raw <= i_lock_raw;
      end
   end

   assign o_lock_stable = (w_run_nxt == SAT);
   assign o_lock_lost   = !i_lock_raw && !r_prev_raw;

endmodule

// File: rtl/serdesphy_link_seq.sv
// PLL/CDR bring-up and recovery sequencer with retry counting and sticky fault.
// All outputs registered from the next state; no backpressure.
module serdesphy_link_seq
   import serdesphy_pkg::*;
#(
   parameter int RST_PULSE   = DEF_RST_PULSE,
   parameter int PLL_TIMEOUT = DEF_PLL_TIMEOUT,
   parameter int CDR_TIMEOUT = DEF_CDR_TIMEOUT,
   parameter int LOCK_FILTER = DEF_LOCK_FILTER,
   parameter int MAX_RETRIES = DEF_MAX_RETRIES
) (
   input  logic       i_clk_ref_24m,
   input  logic       i_rst,
   input  logic       i_phy_en,
   input  logic       i_power_good,
   input  logic       i_sw_restart,
   input  logic       i_pll_lock_raw,
   input  logic       i_cdr_lock_raw,
   output logic       o_pll_rst_out,
   output logic       o_cdr_rst_out,
   output logic       o_tx_enable,
   output logic       o_rx_enable,
   output logic       o_phy_ready,
   output logic [2:0] o_seq_state,
   output logic [3:0] o_retry_count,
   output logic       o_seq_error
);

   localparam int               CNT_W     = $clog2(max3(PLL_TIMEOUT, CDR_TIMEOUT, RST_PULSE) + 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CDR_LAST  = CNT_W'(CDR_TIMEOUT - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   seq_state_e       r_state, w_state_nxt, w_fail_dst;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_retry, w_retry_nxt, w_retry_inc;
   logic             r_error, w_error_nxt;
   logic             w_fail, w_restart, w_cnt_clr;
   logic             w_pll_stable, w_pll_lost, w_cdr_stable, w_cdr_lost;
   logic             r_pll_rst, r_cdr_rst, r_enable;
   logic             w_pll_rst, w_cdr_rst, w_enable;

   serdesphy_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_pll_filt (
      .i_clk         (i_clk_ref_24m),
      .i_rst         (i_rst),
      .i_lock_raw    (i_pll_lock_raw),
      .o_lock_stable (w_pll_stable),
      .o_lock_lost   (w_pll_lost)
   );

   serdesphy_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_cdr_filt (
      .i_clk         (i_clk_ref_24m),
      .i_rst         (i_rst),
      .i_lock_raw    (i_cdr_lock_raw),
      .o_lock_stable (w_cdr_stable),
      .o_lock_lost   (w_cdr_lost)
   );

   assign w_retry_inc = (r_retry == RETRY_SAT) ? RETRY_SAT : r_retry + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_error_nxt = r_error;
      w_fail      = 1'b0;
      w_fail_dst  = SEQ_PLL_RST;
      w_restart   = 1'b0;
      if (!i_phy_en || !i_power_good) begin
         w_state_nxt = SEQ_IDLE;
         w_retry_nxt = '0;
         if (!i_phy_en) w_error_nxt = 1'b0;
      end else if (i_sw_restart) begin
         w_state_nxt = SEQ_PLL_RST;
         w_retry_nxt = '0;
         w_error_nxt = 1'b0;
         w_restart   = 1'b1;
      end else begin
         case (r_state)
            SEQ_IDLE:     w_state_nxt = SEQ_PLL_RST;
            SEQ_PLL_RST:  if (r_cnt == RST_LAST) w_state_nxt = SEQ_PLL_WAIT;
            SEQ_PLL_WAIT: begin
               if (w_pll_stable)           w_state_nxt = SEQ_CDR_RST;
               else if (r_cnt == PLL_LAST) w_fail      = 1'b1;
            end
            SEQ_CDR_RST: begin
               if (w_pll_lost)             w_fail      = 1'b1;
               else if (r_cnt == RST_LAST) w_state_nxt = SEQ_CDR_WAIT;
            end
            SEQ_CDR_WAIT: begin
               if (w_pll_lost)             w_fail      = 1'b1;
               else if (w_cdr_stable)      w_state_nxt = SEQ_READY;
               else if (r_cnt == CDR_LAST) w_fail      = 1'b1;
            end
            SEQ_READY: begin
               // PLL loss wins: the CDR cannot recover without a good PLL.
               if (w_pll_lost) begin
                  w_fail = 1'b1;
               end else if (w_cdr_lost) begin
                  w_fail     = 1'b1;
                  w_fail_dst = SEQ_CDR_RST;
               end
            end
            SEQ_FAULT:    w_state_nxt = SEQ_FAULT;
            default:      w_state_nxt = SEQ_IDLE;
         endcase
         if (w_fail) begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == RETRY_MAX) begin
               w_state_nxt = SEQ_FAULT;
               w_error_nxt = 1'b1;
            end else begin
               w_state_nxt = w_fail_dst;
            end
         end
         if (w_state_nxt == SEQ_READY && r_state != SEQ_READY) w_retry_nxt = '0;
      end
   end

   assign w_cnt_clr = (w_state_nxt != r_state) || w_restart;

   // Output decode from the next state keeps every output registered and aligned with o_seq_state.
   always_comb begin
      w_pll_rst = 1'b1;
      w_cdr_rst = 1'b1;
      w_enable  = 1'b0;
      case (w_state_nxt)
         SEQ_PLL_WAIT,
         SEQ_CDR_RST:  w_pll_rst = 1'b0;
         SEQ_CDR_WAIT: begin
            w_pll_rst = 1'b0;
            w_cdr_rst = 1'b0;
         end
         SEQ_READY: begin
            w_pll_rst = 1'b0;
            w_cdr_rst = 1'b0;
            w_enable  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk_ref_24m) begin
      if (i_rst) begin
         r_state   <= SEQ_IDLE;
         r_cnt     <= '0;
         r_retry   <= '0;
         r_error   <= 1'b0;
         r_pll_rst <= 1'b1;
         r_cdr_rst <= 1'b1;
         r_enable  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_retry   <= w_retry_nxt;
         r_error   <= w_error_nxt;
         r_pll_rst <= w_pll_rst;
         r_cdr_rst <= w_cdr_rst;
         r_enable  <= w_enable;
         if (w_cnt_clr)           r_cnt <= '0;
         else if (r_cnt != '1)    r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_pll_rst_out = r_pll_rst;
   assign o_cdr_rst_out = r_cdr_rst;
   assign o_tx_enable   = r_enable;
   assign o_rx_enable   = r_enable;
   assign o_phy_ready   = r_enable;
   assign o_seq_state   = r_state;
   assign o_retry_count = r_retry;
   assign o_seq_error   = r_error;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Bench for serdesphy_link_seq: directed bring-up/recovery scenarios, then random stimulus,
// every cycle checked against a phase/run-length reference model.
module tb_serdesphy_link_seq;
   import serdesphy_pkg::*;

   localparam int RST_PULSE = 4, PLL_TO = 20, CDR_TO = 20, LF = 3, MAXR = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1, phy_en = 1'b0, power_good = 1'b0, sw_restart = 1'b0;
   logic       pll_raw = 1'b0, cdr_raw = 1'b0;
   logic       pll_rst_out, cdr_rst_out, tx_en, rx_en, phy_ready, seq_error;
   logic [2:0] seq_state;
   logic [3:0] retry_count;

   int n_cmp = 0, n_bad = 0;

   // Reference model: phase number, cycles spent in phase, lock run lengths.
   int m_ph = 0, m_age = 0, m_retry = 0;
   int m_pll_hi = 0, m_pll_lo = 0, m_cdr_hi = 0, m_cdr_lo = 0;
   bit m_err = 1'b0;

   always #5 clk = ~clk;

   serdesphy_link_seq #(
      .RST_PULSE(RST_PULSE), .PLL_TIMEOUT(PLL_TO), .CDR_TIMEOUT(CDR_TO),
      .LOCK_FILTER(LF), .MAX_RETRIES(MAXR)
   ) dut (
      .i_clk_ref_24m (clk),
      .i_rst         (rst),
      .i_phy_en      (phy_en),
      .i_power_good  (power_good),
      .i_sw_restart  (sw_restart),
      .i_pll_lock_raw(pll_raw),
      .i_cdr_lock_raw(cdr_raw),
      .o_pll_rst_out (pll_rst_out),
      .o_cdr_rst_out (cdr_rst_out),
      .o_tx_enable   (tx_en),
      .o_rx_enable   (rx_en),
      .o_phy_ready   (phy_ready),
      .o_seq_state   (seq_state),
      .o_retry_count (retry_count),
      .o_seq_error   (seq_error)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit pll_ok, pll_gone, cdr_ok, cdr_gone, fail, restarted;
      int nxt, fail_dst;
      if (rst) begin
         m_ph = 0; m_age = 0; m_retry = 0; m_err = 1'b0;
         m_pll_hi = 0; m_pll_lo = 0; m_cdr_hi = 0; m_cdr_lo = 0;
         return;
      end
      m_pll_hi = pll_raw ? m_pll_hi + 1 : 0;
      m_pll_lo = pll_raw ? 0 : m_pll_lo + 1;
      m_cdr_hi = cdr_raw ? m_cdr_hi + 1 : 0;
      m_cdr_lo = cdr_raw ? 0 : m_cdr_lo + 1;
      pll_ok = (m_pll_hi >= LF); pll_gone = (m_pll_lo >= 2);
      cdr_ok = (m_cdr_hi >= LF); cdr_gone = (m_cdr_lo >= 2);
      m_age++;
      nxt = m_ph; fail = 1'b0; fail_dst = 1; restarted = 1'b0;
      if (!phy_en || !power_good) begin
         nxt = 0; m_retry = 0;
         if (!phy_en) m_err = 1'b0;
      end else if (sw_restart) begin
         nxt = 1; m_retry = 0; m_err = 1'b0; restarted = 1'b1;
      end else begin
         case (m_ph)
            0: nxt = 1;
            1: if (m_age == RST_PULSE) nxt = 2;
            2: if (pll_ok) nxt = 3; else if (m_age == PLL_TO) fail = 1'b1;
            3: if (pll_gone) fail = 1'b1; else if (m_age == RST_PULSE) nxt = 4;
            4: if (pll_gone) fail = 1'b1; else if (cdr_ok) nxt = 5;
               else if (m_age == CDR_TO) fail = 1'b1;
            5: if (pll_gone) fail = 1'b1;
               else if (cdr_gone) begin fail = 1'b1; fail_dst = 3; end
            default: ;
         endcase
         if (fail) begin
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
            nxt = (m_retry == MAXR) ? 6 : fail_dst;
            if (nxt == 6) m_err = 1'b1;
         end
         if (nxt == 5 && m_ph != 5) m_retry = 0;
      end
      if (nxt != m_ph || restarted) m_age = 0;
      m_ph = nxt;
   endtask

   function automatic logic [5:0] m_outs();
      bit pr, cr, up;
      pr = (m_ph == 0) || (m_ph == 1) || (m_ph == 6);
      cr = pr || (m_ph == 2) || (m_ph == 3);
      up = (m_ph == 5);
      return {pr, cr, up, up, up, m_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk_eq("state", seq_state, m_ph);
      chk_eq("retry", retry_count, m_retry);
      chk_eq("outs", {pll_rst_out, cdr_rst_out, tx_en, rx_en, phy_ready, seq_error}, m_outs());
   endtask

   task automatic wait_state(input int s, input int limit, input string tag);
      int n = 0;
      while (seq_state != s && n < limit) begin
         tick();
         n++;
      end
      chk_eq(tag, seq_state, s);
   endtask

   initial begin
      int n, k, wait_cyc;
      int dur[7];
      int seen[3];
      logic [2:0] prev;
      logic [5:0] pat;

      // Reset state
      repeat (3) tick();
      chk_eq("rst_state", seq_state, 0);
      chk_eq("rst_outs", {pll_rst_out, cdr_rst_out, tx_en, rx_en, phy_ready, seq_error}, 6'b110000);
      chk_eq("rst_retry", retry_count, 0);

      // 1: nominal bring-up
      rst = 1'b0; phy_en = 1'b1; power_good = 1'b1;
      foreach (dur[i]) dur[i] = 0;
      n = 0;
      while (!phy_ready && n < 60) begin
         tick();
         n++;
         if (!phy_ready) dur[seq_state]++;
         pll_raw = seq_state inside {3'd2, 3'd3, 3'd4, 3'd5};
         cdr_raw = seq_state inside {3'd4, 3'd5};
      end
      chk_eq("t1_ready_latency", n, 15);
      chk_eq("t1_pll_rst_cyc", dur[1], 4);
      chk_eq("t1_pll_wait_cyc", dur[2], 3);
      chk_eq("t1_cdr_rst_cyc", dur[3], 4);
      chk_eq("t1_cdr_wait_cyc", dur[4], 3);
      chk_eq("t1_retry", retry_count, 0);

      // 3: CDR loss in READY
      cdr_raw = 1'b0; tick(); cdr_raw = 1'b1;
      repeat (4) tick();
      chk_eq("t3_glitch_state", seq_state, 5);
      chk_eq("t3_glitch_ready", phy_ready, 1);
      cdr_raw = 1'b0; tick();
      chk_eq("t3_one_low_ready", phy_ready, 1);
      tick();
      chk_eq("t3_loss_state", seq_state, 3);
      chk_eq("t3_loss_en", {tx_en, rx_en, phy_ready}, 3'b000);
      chk_eq("t3_loss_retry", retry_count, 1);
      cdr_raw = 1'b1;
      wait_state(5, 30, "t3_relock_state");
      chk_eq("t3_relock_retry", retry_count, 0);

      // 6: rst in READY with phy_en still high
      rst = 1'b1; tick();
      chk_eq("t6_state", seq_state, 0);
      chk_eq("t6_outs", {pll_rst_out, cdr_rst_out, tx_en, rx_en, phy_ready, seq_error}, 6'b110000);
      chk_eq("t6_retry", retry_count, 0);

      // 4: glitch while the PLL filter is filling
      pll_raw = 1'b0; cdr_raw = 1'b0; rst = 1'b0;
      wait_state(2, 20, "t4_reach_pll_wait");
      pat = 6'b111011;
      for (int i = 0; i < 6; i++) begin
         pll_raw = pat[i];
         tick();
         chk_eq("t4_state", seq_state, (i == 5) ? 3 : 2);
      end

      // 5: phy_en dropped mid CDR_WAIT
      wait_state(4, 10, "t5_reach_cdr_wait");
      tick(); tick();
      phy_en = 1'b0; tick();
      chk_eq("t5_state", seq_state, 0);
      chk_eq("t5_outs", {pll_rst_out, cdr_rst_out, tx_en, rx_en, phy_ready}, 5'b11000);
      chk_eq("t5_retry", retry_count, 0);
      phy_en = 1'b1; tick();
      chk_eq("t5_restart_state", seq_state, 1);

      // 2: PLL never locks
      pll_raw = 1'b0; cdr_raw = 1'b0;
      sw_restart = 1'b1; tick(); sw_restart = 1'b0;
      chk_eq("t2_start_state", seq_state, 1);
      wait_cyc = 0; k = 0; n = 0; prev = seq_state;
      foreach (seen[i]) seen[i] = 0;
      while (seq_state != 6 && n < 150) begin
         tick();
         n++;
         if (seq_state == 2) wait_cyc++;
         if (prev == 2 && seq_state != 2) begin
            if (k < 3) seen[k] = retry_count;
            k++;
         end
         prev = seq_state;
      end
      chk_eq("t2_wait_cycles", wait_cyc, 60);
      chk_eq("t2_windows", k, 3);
      chk_eq("t2_retry_1", seen[0], 1);
      chk_eq("t2_retry_2", seen[1], 2);
      chk_eq("t2_retry_3", seen[2], 3);
      chk_eq("t2_fault_state", seq_state, 6);
      chk_eq("t2_fault_err", seq_error, 1);
      chk_eq("t2_fault_pll_rst", pll_rst_out, 1);
      repeat (3) tick();
      chk_eq("t2_fault_hold", seq_state, 6);
      sw_restart = 1'b1; tick(); sw_restart = 1'b0;
      chk_eq("t2_restart_state", seq_state, 1);
      chk_eq("t2_restart_retry", retry_count, 0);
      chk_eq("t2_restart_err", seq_error, 0);

      // Random stimulus against the model
      for (int c = 0; c < 6000; c++) begin
         rst        = ($urandom_range(999) == 0);
         sw_restart = ($urandom_range(149) == 0);
         phy_en     = phy_en ? ($urandom_range(399) != 0) : ($urandom_range(7) == 0);
         power_good = power_good ? ($urandom_range(799) != 0) : ($urandom_range(7) == 0);
         if (pll_raw) pll_raw = ($urandom_range(29) != 0); else pll_raw = ($urandom_range(3) == 0);
         if (cdr_raw) cdr_raw = ($urandom_range(19) != 0); else cdr_raw = ($urandom_range(3) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
